vga_sync_monitor: RTL and testbench
===================================

Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator. Consumes hsync/vsync/display-enable in the pixel clock domain.
- Recovers the pixel coordinates, measures total and active frame geometry, and asserts lock after consecutive identical frames.
- Used for display-path self-check and as the front end of a frame-capture path fed by generator-format timing.

Parameters:
- CNT_W, 11, width of all internal and measured counters (max 2047 clocks/line, 2047 lines/frame)
- LOCK_FRAMES, 2, consecutive matching frames after the reference frame required to lock (range 1..15)

Ports:
- clk  input  1  pixel clock
- reset  input  1  synchronous, active-high
- hsync_in  input  1  horizontal sync, active-high, same clock domain
- vsync_in  input  1  vertical sync, active-high, same clock domain
- de_in  input  1  display enable (active video)
- pixel_valid  output  1  registered copy of de_in, aligned with x/y
- x  output  10  column within active line
- y  output  10  active line index within frame
- frame_start  output  1  one-cycle pulse per vsync rising edge
- locked  output  1  timing stable
- timing_error  output  1  one-cycle pulse on loss of lock
- h_total  output  CNT_W  clocks per line (reference value)
- v_total  output  CNT_W  lines per frame
- h_active  output  CNT_W  de-high clocks per line
- v_active  output  CNT_W  lines containing de per frame

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - all outputs 0; state SEARCH; all counters and previous-input registers 0.
  - Reset mid-frame discards all measurements; the previous-input registers at 0 mean a high input on the first post-reset cycle counts as a rising edge.
- Edge detection: previous-input registers h_q, v_q, de_q.
  - hrise = hsync_in & ~h_q; vrise = vsync_in & ~v_q; derise/defall likewise.
  - Everything acts in the detect cycle; outputs change at the next clk edge (latency 1).
- Horizontal counter hcnt:
  - On hrise: cur_len <= hcnt+1, hcnt <= 0; otherwise hcnt+1.
  - Saturates at all-ones; saturation is loss of sync.
  - Within a frame, the first hrise after the frame's first line fixes the frame's line length; any later differing cur_len sets frame_bad.
- Vertical counter vcnt:
  - Increments on hrise.
  - On vrise: frame_lines <= vcnt, vcnt <= hrise ? 1 : 0. A simultaneous hrise belongs to the new frame.
- Active width: counts de-high cycles; latched on defall. Differing widths within a frame set frame_bad.
- Active height: counts derise events, latched and cleared on vrise.
- Frame tuple: {line length, frame_lines, active width, active height} evaluated at each vrise.
- State machine, transitions only on vrise unless noted:
  - SEARCH: first vrise -> MEASURE. The partial frame is discarded.
  - MEASURE: if frame_bad, stay. Else ref <= tuple, match_cnt <= 0, -> VERIFY.
  - VERIFY:
    - tuple==ref and !frame_bad: match_cnt+1; reaching LOCK_FRAMES -> LOCKED.
    - tuple differs, !frame_bad: ref <= tuple, match_cnt <= 0, stay.
    - frame_bad: -> MEASURE.
  - LOCKED:
    - mismatch or frame_bad: timing_error pulse, -> MEASURE.
    - A line-length mismatch mid-frame exits immediately (not at vrise), with timing_error.
  - Any state: hcnt or vcnt saturation -> SEARCH; timing_error pulses only if leaving LOCKED.
  - frame_bad clears on every vrise.
- locked = (state==LOCKED), registered. h_total/v_total/h_active/v_active drive ref; update only when ref is loaded, hold otherwise.
- Coordinates:
  - pixel_valid <= de_in.
  - x <= derise ? 0 : x+1 while de_in; holds when de_in low.
  - y <= 0 on the first derise after vrise, y+1 on subsequent derise; holds otherwise.
  - x/y wrap modulo 1024; not gated by locked.
- frame_start <= vrise.

Test Plan:
- Standard 640x480 timing, 800x525 totals, de 640x480, frames back-to-back from reset -> frame_start on each vsync rise; locked rises 1 cycle after 4th vrise (SEARCH, MEASURE, 2 verifies); h_total=800, v_total=525, h_active=640, v_active=480; timing_error never pulses.
- Small frame 10 clk x 6 lines, de 4x3 -> first active pixel x=0,y=0; last active pixel x=3,y=2; pixel_valid exactly 12 cycles/frame; x/y hold between lines.
- Locked at 10x6, then one line shortened to 9 clk -> timing_error 1-cycle pulse at that hrise+1, locked drops; relock after 3 further clean frames.
- Frame height changes 6->7 lines persistently while locked -> error at next vrise; outputs update to v_total=7 at next MEASURE exit; relock.
- hsync stuck low 2047+ cycles while locked -> timing_error, state SEARCH, locked=0; resumes normal lock sequence when sync returns.
- Reset asserted mid-frame while locked -> next cycle all outputs 0; vrise coinciding with hrise -> new frame's vcnt starts at 1, v_total unchanged.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from hsync/vsync/de,
// measures frame geometry and declares lock after repeated identical frames.
module vga_sync_monitor #(
  parameter int CNT_W       = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  output logic             pixel_valid,
  output logic [9:0]       x,
  output logic [9:0]       y,
  output logic             frame_start,
  output logic             locked,
  output logic             timing_error,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active
);
  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic             h_q, v_q, de_q;
  logic             hrise, vrise, derise, defall;
  logic [CNT_W-1:0] hcnt, vcnt, cur_len, len_ref;
  logic [CNT_W-1:0] aw_cnt, aw_ref, ah_cnt;
  logic [CNT_W-1:0] ref_h, ref_v, ref_aw, ref_ah;
  logic [CNT_W-1:0] t_h, t_w;
  logic             len_set, aw_set, frame_bad, y_first;
  logic             len_meas, len_bad, lock_len_bad, width_bad, bad_now;
  logic             hsat, vsat, tuple_match, load_ref, err;
  logic [3:0]       match_cnt, match_next, match_inc;

  assign hrise  = hsync_in & ~h_q;
  assign vrise  = vsync_in & ~v_q;
  assign derise = de_in & ~de_q;
  assign defall = ~de_in & de_q;

  assign cur_len = hcnt + ONE;
  // A line is only measured if an hrise already opened it inside this frame.
  assign len_meas     = hrise & (vcnt != '0);
  assign len_bad      = len_meas & len_set & (cur_len != len_ref);
  assign lock_len_bad = len_meas & (state == LOCKED) & (cur_len != ref_h);
  assign width_bad    = defall & aw_set & (aw_cnt != aw_ref);
  assign bad_now      = frame_bad | len_bad | lock_len_bad | width_bad;

  assign hsat = (&hcnt) & ~hrise;
  assign vsat = &vcnt;

  assign t_h = len_set ? len_ref : (len_meas ? cur_len : '0);
  assign t_w = aw_set  ? aw_ref  : (defall ? aw_cnt : '0);
  assign tuple_match = (t_h == ref_h) && (vcnt == ref_v) &&
                       (t_w == ref_aw) && (ah_cnt == ref_ah);
  assign match_inc = match_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      match_cnt <= '0;
    end else begin
      state     <= state_next;
      match_cnt <= match_next;
    end
  end

  always_comb begin
    state_next = state;
    match_next = match_cnt;
    load_ref   = 1'b0;
    err        = 1'b0;
    if (hsat || vsat) begin
      state_next = SEARCH;
      err        = (state == LOCKED);
    end else if (vrise) begin
      case (state)
        SEARCH:  state_next = MEASURE;
        MEASURE: if (!bad_now) begin
          load_ref   = 1'b1;
          match_next = '0;
          state_next = VERIFY;
        end
        VERIFY: begin
          if (bad_now) begin
            state_next = MEASURE;
          end else if (tuple_match) begin
            match_next = match_inc;
            if (match_inc == 4'(LOCK_FRAMES)) state_next = LOCKED;
          end else begin
            load_ref   = 1'b1;
            match_next = '0;
          end
        end
        LOCKED: if (bad_now || !tuple_match) begin
          err        = 1'b1;
          state_next = MEASURE;
        end
        default: state_next = SEARCH;
      endcase
    end else if (lock_len_bad) begin
      err        = 1'b1;
      state_next = MEASURE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= 1'b0; v_q <= 1'b0; de_q <= 1'b0;
      hcnt <= '0; vcnt <= '0;
      len_ref <= '0; len_set <= 1'b0;
      aw_cnt <= '0; aw_ref <= '0; aw_set <= 1'b0;
      ah_cnt <= '0; frame_bad <= 1'b0;
      ref_h <= '0; ref_v <= '0; ref_aw <= '0; ref_ah <= '0;
    end else begin
      h_q  <= hsync_in;
      v_q  <= vsync_in;
      de_q <= de_in;

      if (hrise)       hcnt <= '0;
      else if (!(&hcnt)) hcnt <= hcnt + ONE;

      // An hrise coincident with vrise opens line 1 of the new frame.
      if (vrise)                 vcnt <= hrise ? ONE : '0;
      else if (hrise && !(&vcnt)) vcnt <= vcnt + ONE;

      if (vrise) len_set <= 1'b0;
      else if (len_meas && !len_set) begin
        len_ref <= cur_len;
        len_set <= 1'b1;
      end

      if (derise)                aw_cnt <= ONE;
      else if (de_in && !(&aw_cnt)) aw_cnt <= aw_cnt + ONE;

      if (vrise) aw_set <= 1'b0;
      else if (defall && !aw_set) begin
        aw_ref <= aw_cnt;
        aw_set <= 1'b1;
      end

      if (vrise)                  ah_cnt <= derise ? ONE : '0;
      else if (derise && !(&ah_cnt)) ah_cnt <= ah_cnt + ONE;

      if (vrise) frame_bad <= 1'b0;
      else if (len_bad || lock_len_bad || width_bad) frame_bad <= 1'b1;

      if (load_ref) begin
        ref_h  <= t_h;
        ref_v  <= vcnt;
        ref_aw <= t_w;
        ref_ah <= ah_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_valid  <= 1'b0;
      x            <= '0;
      y            <= '0;
      y_first      <= 1'b0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      pixel_valid <= de_in;
      if (de_in) x <= derise ? 10'd0 : x + 10'd1;
      if (derise) y <= (y_first || vrise) ? 10'd0 : y + 10'd1;
      if (vrise)       y_first <= ~derise;
      else if (derise) y_first <= 1'b0;
      frame_start  <= vrise;
      locked       <= (state_next == LOCKED);
      timing_error <= err;
    end
  end

  assign h_total  = ref_h;
  assign v_total  = ref_v;
  assign h_active = ref_aw;
  assign v_active = ref_ah;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor: a table of frames with expected lock/geometry
// state at each frame start, plus hand sequences for sync loss and mid-frame reset.
module tb_vga_sync_monitor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, de_in = 1'b0;
  logic        pixel_valid, frame_start, locked, timing_error;
  logic [9:0]  x, y;
  logic [10:0] h_total, v_total, h_active, v_active;

  int errors = 0;
  int checks = 0;

  vga_sync_monitor #(.CNT_W(11), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .pixel_valid(pixel_valid), .x(x), .y(y), .frame_start(frame_start), .locked(locked),
    .timing_error(timing_error), .h_total(h_total), .v_total(v_total),
    .h_active(h_active), .v_active(v_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   h, v, aw, av, short_line, short_len;
    bit   stall;
    logic exp_locked;
    int   exp_ht, exp_vt, exp_ha, exp_va;
    logic exp_err;
    int   exp_mid;
  } vec_t;

  vec_t vec[19];

  function automatic vec_t mk(input int v, input int sl, input bit st, input logic lk,
                              input int ht, input int vt, input int ha, input int va,
                              input logic er, input int mid);
    vec_t r;
    r.h = 10; r.v = v; r.aw = 4; r.av = 3; r.short_line = sl; r.short_len = 9;
    r.stall = st; r.exp_locked = lk; r.exp_ht = ht; r.exp_vt = vt;
    r.exp_ha = ha; r.exp_va = va; r.exp_err = er; r.exp_mid = mid;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t r);
    int len, pv, fs_body, err_body;
    pv = 0; fs_body = 0; err_body = 0;
    for (int l = 0; l < r.v; l++) begin
      len = (l == r.short_line) ? r.short_len : r.h;
      for (int c = 0; c < len; c++) begin
        hsync_in = (c < 2);
        vsync_in = (l == 0);
        de_in    = (l >= 1) && (l <= r.av) && (c >= 3) && (c < 3 + r.aw);
        @(posedge clk); #1;
        if (pixel_valid) pv++;
        if (l == 0 && c == 0) begin
          chk("frame_start", frame_start, 1);
          chk("locked", locked, r.exp_locked);
          chk("timing_error_vrise", timing_error, r.exp_err);
          chk("h_total", h_total, r.exp_ht);
          chk("v_total", v_total, r.exp_vt);
          chk("h_active", h_active, r.exp_ha);
          chk("v_active", v_active, r.exp_va);
        end else begin
          if (frame_start) fs_body++;
          if (timing_error) err_body++;
        end
        if (r.short_line >= 0 && l == r.short_line + 1 && c == 0) begin
          chk("short_line_err", timing_error, 1);
          chk("short_line_unlock", locked, 0);
        end
        if (de_in) begin
          chk("x_active", x, c - 3);
          chk("y_active", y, l - 1);
        end else if (l >= 1 && l <= r.av && c == len - 1) begin
          chk("x_hold", x, r.aw - 1);
          chk("y_hold", y, l - 1);
        end
      end
    end
    chk("pixel_valid_count", pv, r.aw * r.av);
    chk("frame_start_body", fs_body, 0);
    chk("timing_error_body", err_body, r.exp_mid);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vec[0]  = mk(6, -1, 0, 0,  0, 0, 0, 0, 0, 0);
    vec[1]  = mk(6, -1, 0, 0, 10, 6, 4, 3, 0, 0);
    vec[2]  = mk(6, -1, 0, 0, 10, 6, 4, 3, 0, 0);
    vec[3]  = mk(6, -1, 0, 1, 10, 6, 4, 3, 0, 0);
    vec[4]  = mk(6, -1, 0, 1, 10, 6, 4, 3, 0, 0);
    vec[5]  = mk(6,  3, 0, 1, 10, 6, 4, 3, 0, 1);
    vec[6]  = mk(6, -1, 0, 0, 10, 6, 4, 3, 0, 0);
    vec[7]  = mk(6, -1, 0, 0, 10, 6, 4, 3, 0, 0);
    vec[8]  = mk(6, -1, 0, 0, 10, 6, 4, 3, 0, 0);
    vec[9]  = mk(7, -1, 0, 1, 10, 6, 4, 3, 0, 0);
    vec[10] = mk(7, -1, 0, 0, 10, 6, 4, 3, 1, 0);
    vec[11] = mk(7, -1, 0, 0, 10, 7, 4, 3, 0, 0);
    vec[12] = mk(7, -1, 0, 0, 10, 7, 4, 3, 0, 0);
    vec[13] = mk(7, -1, 0, 1, 10, 7, 4, 3, 0, 0);
    vec[14] = mk(6, -1, 1, 0, 10, 7, 4, 3, 0, 0);
    vec[15] = mk(6, -1, 0, 0, 10, 6, 4, 3, 0, 0);
    vec[16] = mk(6, -1, 0, 0, 10, 6, 4, 3, 0, 0);
    vec[17] = mk(6, -1, 0, 1, 10, 6, 4, 3, 0, 0);
    vec[18] = mk(6, -1, 0, 1, 10, 6, 4, 3, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_h_total", h_total, 0);
    chk("rst_x", x, 0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      if (vec[i].stall) begin
        // Sync disappears entirely; the line counter must saturate and drop lock.
        hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
        seen = 0;
        for (int k = 0; k < 2200; k++) begin
          @(posedge clk); #1;
          if (timing_error) seen++;
        end
        chk("stall_err_pulses", seen, 1);
        chk("stall_locked", locked, 0);
      end
      run_frame(vec[i]);
    end

    // Reset in the middle of a locked frame.
    hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_locked", locked, 1);
    hsync_in = 1'b0; vsync_in = 1'b1; de_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_x", x, 2);
    reset = 1'b1; hsync_in = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_pixel_valid", pixel_valid, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_frame_start", frame_start, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_timing_error", timing_error, 0);
    chk("mid_rst_h_total", h_total, 0);
    chk("mid_rst_v_total", v_total, 0);
    chk("mid_rst_h_active", h_active, 0);
    chk("mid_rst_v_active", v_active, 0);
    reset = 1'b0;
    // Inputs high across reset still register as rising edges afterwards.
    run_frame(vec[0]);
    run_frame(vec[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
